// File: rtl/mandelbrot_pipe.sv
// Flow-controlled escape-time pipeline: one z <- z^2 + c iteration per stage, one pixel per clock.
// Optional Julia mode (z0 = pixel, c = constant k) is enabled by defining MANDELBROT_JULIA_EN.
`timescale 1ns/1ps
module mandelbrot_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 22,
    parameter int STAGES = 32,
    parameter int TAG_W  = 16,
    localparam int ITER_W = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  c_real_in,
    input  logic [WIDTH-1:0]  c_imag_in,
    input  logic [TAG_W-1:0]  tag_in,
`ifdef MANDELBROT_JULIA_EN
    input  logic              julia_mode,
    input  logic [WIDTH-1:0]  k_real,
    input  logic [WIDTH-1:0]  k_imag,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              escaped,
    output logic [ITER_W-1:0] iters,
    output logic [WIDTH-1:0]  real_out,
    output logic [WIDTH-1:0]  imag_out,
    output logic [TAG_W-1:0]  tag_out
);

    localparam logic [2*WIDTH:0] MAG_LIMIT = (2*WIDTH+1)'(4) << (2*FRAC);

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    logic signed [WIDTH-1:0] z0_real, z0_imag, c0_real, c0_imag;

`ifdef MANDELBROT_JULIA_EN
    assign z0_real = julia_mode ? c_real_in : '0;
    assign z0_imag = julia_mode ? c_imag_in : '0;
    assign c0_real = julia_mode ? k_real : c_real_in;
    assign c0_imag = julia_mode ? k_imag : c_imag_in;
`else
    assign z0_real = '0;
    assign z0_imag = '0;
    assign c0_real = c_real_in;
    assign c0_imag = c_imag_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : stage
            logic                    vld_reg, esc_reg;
            logic [ITER_W-1:0]       it_reg;
            logic signed [WIDTH-1:0] zr_reg, zi_reg;
            logic [TAG_W-1:0]        tag_reg;

            logic                    vld_cur, esc_cur;
            logic [ITER_W-1:0]       it_cur;
            logic signed [WIDTH-1:0] zr_cur, zi_cur, cr_cur, ci_cur;
            logic [TAG_W-1:0]        tag_cur;

            if (gi == 0) begin : src
                assign vld_cur = in_valid;
                assign esc_cur = 1'b0;
                assign it_cur  = '0;
                assign zr_cur  = z0_real;
                assign zi_cur  = z0_imag;
                assign cr_cur  = c0_real;
                assign ci_cur  = c0_imag;
                assign tag_cur = tag_in;
            end else begin : src
                assign vld_cur = stage[gi-1].vld_reg;
                assign esc_cur = stage[gi-1].esc_reg;
                assign it_cur  = stage[gi-1].it_reg;
                assign zr_cur  = stage[gi-1].zr_reg;
                assign zi_cur  = stage[gi-1].zi_reg;
                assign cr_cur  = stage[gi-1].carry.cr_reg;
                assign ci_cur  = stage[gi-1].carry.ci_reg;
                assign tag_cur = stage[gi-1].tag_reg;
            end

            // Full-precision products; the extra top bits make saturation exact.
            logic signed [2*WIDTH-1:0] sq_r, sq_i, prod;
            logic [2*WIDTH:0]          mag;
            logic signed [2*WIDTH:0]   diff, dbl, re_shift, im_shift;
            logic signed [2*WIDTH+1:0] re_wide, im_wide;
            logic                      re_ovf, im_ovf;
            logic signed [WIDTH-1:0]   re_sat, im_sat;

            assign sq_r     = zr_cur * zr_cur;
            assign sq_i     = zi_cur * zi_cur;
            assign prod     = zr_cur * zi_cur;
            assign mag      = {sq_r[2*WIDTH-1], sq_r} + {sq_i[2*WIDTH-1], sq_i};
            assign diff     = {sq_r[2*WIDTH-1], sq_r} - {sq_i[2*WIDTH-1], sq_i};
            assign dbl      = {prod, 1'b0};
            assign re_shift = diff >>> FRAC;
            assign im_shift = dbl >>> FRAC;
            assign re_wide  = {re_shift[2*WIDTH], re_shift} + {{(WIDTH+2){cr_cur[WIDTH-1]}}, cr_cur};
            assign im_wide  = {im_shift[2*WIDTH], im_shift} + {{(WIDTH+2){ci_cur[WIDTH-1]}}, ci_cur};
            assign re_ovf   = ~((&re_wide[2*WIDTH+1:WIDTH-1]) | ~(|re_wide[2*WIDTH+1:WIDTH-1]));
            assign im_ovf   = ~((&im_wide[2*WIDTH+1:WIDTH-1]) | ~(|im_wide[2*WIDTH+1:WIDTH-1]));
            assign re_sat   = re_ovf ? {re_wide[2*WIDTH+1], {(WIDTH-1){~re_wide[2*WIDTH+1]}}}
                                     : re_wide[WIDTH-1:0];
            assign im_sat   = im_ovf ? {im_wide[2*WIDTH+1], {(WIDTH-1){~im_wide[2*WIDTH+1]}}}
                                     : im_wide[WIDTH-1:0];

            logic                    esc_next;
            logic [ITER_W-1:0]       it_next;
            logic signed [WIDTH-1:0] zr_next, zi_next;

            always_comb begin
                esc_next = esc_cur;
                it_next  = it_cur;
                zr_next  = zr_cur;
                zi_next  = zi_cur;
                if (!esc_cur) begin
                    if (mag >= MAG_LIMIT) begin
                        esc_next = 1'b1;
                        it_next  = ITER_W'(gi);
                    end else begin
                        zr_next  = re_sat;
                        zi_next  = im_sat;
                        it_next  = ITER_W'(gi + 1);
                        esc_next = re_ovf | im_ovf;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_reg <= 1'b0;
                    esc_reg <= 1'b0;
                    it_reg  <= '0;
                    zr_reg  <= '0;
                    zi_reg  <= '0;
                    tag_reg <= '0;
                end else if (advance) begin
                    vld_reg <= vld_cur;
                    esc_reg <= esc_next;
                    it_reg  <= it_next;
                    zr_reg  <= zr_next;
                    zi_reg  <= zi_next;
                    tag_reg <= tag_cur;
                end
            end

            // The final stage has no successor, so c stops here.
            if (gi < STAGES - 1) begin : carry
                logic signed [WIDTH-1:0] cr_reg, ci_reg;
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        cr_reg <= '0;
                        ci_reg <= '0;
                    end else if (advance) begin
                        cr_reg <= cr_cur;
                        ci_reg <= ci_cur;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stage[STAGES-1].vld_reg;
    assign escaped   = stage[STAGES-1].esc_reg;
    assign iters     = stage[STAGES-1].it_reg;
    assign real_out  = stage[STAGES-1].zr_reg;
    assign imag_out  = stage[STAGES-1].zi_reg;
    assign tag_out   = stage[STAGES-1].tag_reg;

endmodule

// File: tb/tb_mandelbrot_pipe.sv
// Scoreboard bench for mandelbrot_pipe: directed pixels, output stall, and mid-stream reset.
`timescale 1ns/1ps
module tb_mandelbrot_pipe;
    localparam int WIDTH = 32, FRAC = 22, STAGES = 32, TAG_W = 16, ITER_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, in_valid, in_ready, out_valid, out_ready, escaped;
    logic [WIDTH-1:0]  c_real_in, c_imag_in, real_out, imag_out;
    logic [TAG_W-1:0]  tag_in, tag_out;
    logic [ITER_W-1:0] iters;
`ifdef MANDELBROT_JULIA_EN
    logic              julia_mode;
    logic [WIDTH-1:0]  k_real, k_imag;
`endif

    typedef struct {
        logic              esc;
        logic [ITER_W-1:0] it;
        logic [WIDTH-1:0]  zr;
        logic [WIDTH-1:0]  zi;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, n_out = 0, n_before = 0;
    logic stall_arm = 1'b0, stall_done = 1'b0;

    mandelbrot_pipe #(.WIDTH(WIDTH), .FRAC(FRAC), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .c_real_in(c_real_in), .c_imag_in(c_imag_in), .tag_in(tag_in),
`ifdef MANDELBROT_JULIA_EN
        .julia_mode(julia_mode), .k_real(k_real), .k_imag(k_imag),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .escaped(escaped), .iters(iters),
        .real_out(real_out), .imag_out(imag_out), .tag_out(tag_out)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("check %s ok value=%h", name, got);
        end
    endtask

    // Called at posedge+2; returns at posedge+2 of the cycle after the transfer.
    task automatic send(input logic [31:0] cr, input logic [31:0] ci, input logic [15:0] tag,
                        input logic e, input logic [5:0] it,
                        input logic [31:0] ezr, input logic [31:0] ezi);
        exp_t x;
        int   tries;
        logic ok;
        c_real_in = cr;
        c_imag_in = ci;
        tag_in    = tag;
        in_valid  = 1'b1;
        tries = 0;
        ok    = 1'b0;
        while (!ok && tries < 200) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) begin
                x.esc = e; x.it = it; x.zr = ezr; x.zi = ezi; x.tag = tag;
                sb.push_back(x);
            end
            @(posedge clk); #2;
            tries++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout tag=%h got in_ready=0 want in_ready=1", tag);
        end
        in_valid = 1'b0;
    endtask

`ifdef MANDELBROT_JULIA_EN
    task automatic send_julia(input logic [31:0] zr0, input logic [31:0] zi0,
                              input logic [31:0] kr, input logic [31:0] ki, input logic [15:0] tag,
                              input logic e, input logic [5:0] it,
                              input logic [31:0] ezr, input logic [31:0] ezi);
        julia_mode = 1'b1;
        k_real     = kr;
        k_imag     = ki;
        send(zr0, zi0, tag, e, it, ezr, ezi);
        julia_mode = 1'b0;
    endtask
`endif

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    // Monitor: a result transfers at the posedge following a negedge with valid & ready.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset && out_valid && out_ready) begin
                n_out++;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got tag=%h esc=%0d iters=%0d want no output",
                             tag_out, escaped, iters);
                end else begin
                    x = sb.pop_front();
                    if (escaped !== x.esc || iters !== x.it || real_out !== x.zr ||
                        imag_out !== x.zi || tag_out !== x.tag) begin
                        failures++;
                        $display("FAIL result got tag=%h esc=%0d iters=%0d re=%h im=%h want tag=%h esc=%0d iters=%0d re=%h im=%h",
                                 tag_out, escaped, iters, real_out, imag_out,
                                 x.tag, x.esc, x.it, x.zr, x.zi);
                    end else begin
                        $display("result tag=%h esc=%0d iters=%0d re=%h im=%h ok",
                                 tag_out, escaped, iters, real_out, imag_out);
                    end
                end
            end
        end
    end

    // Sink: holds out_ready low for 5 cycles on the first result after stall_arm.
    initial begin
        logic [87:0] cap;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_arm && out_valid && reset) begin
                stall_arm = 1'b0;
                out_ready = 1'b0;
                cap = {escaped, iters, real_out, imag_out, tag_out, out_valid};
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                    chk("stall_hold", {24'd0, escaped, iters, real_out, imag_out, tag_out, out_valid},
                        {24'd0, cap});
                    @(posedge clk); #1;
                end
                out_ready  = 1'b1;
                stall_done = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; c_real_in = '0; c_imag_in = '0; tag_in = '0;
`ifdef MANDELBROT_JULIA_EN
        julia_mode = 1'b0; k_real = '0; k_imag = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_escaped",   {63'd0, escaped},   64'd0);
        chk("reset_iters",     {58'd0, iters},     64'd0);
        chk("reset_real_out",  {32'd0, real_out},  64'd0);
        chk("reset_imag_out",  {32'd0, imag_out},  64'd0);
        chk("reset_tag_out",   {48'd0, tag_out},   64'd0);
        chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;

        send(32'h00000000, 32'h00000000, 16'h0005, 1'b0, 6'd32, 32'h00000000, 32'h00000000);
        send(32'h00800000, 32'h00000000, 16'h0011, 1'b1, 6'd1,  32'h00800000, 32'h00000000);
        send(32'h00400000, 32'h00000000, 16'h0012, 1'b1, 6'd2,  32'h00800000, 32'h00000000);
        send(32'hFF800000, 32'h00000000, 16'h0013, 1'b1, 6'd1,  32'hFF800000, 32'h00000000);
        idle(1);
        send(32'h00000000, 32'h00400000, 16'h0014, 1'b0, 6'd32, 32'hFFC00000, 32'h00400000);
        send(32'hFFC00000, 32'h00000000, 16'h0015, 1'b0, 6'd32, 32'h00000000, 32'h00000000);
        send(32'h00200000, 32'h00000000, 16'h0016, 1'b1, 6'd5,  32'h00C9D040, 32'h00000000);
        send(32'h00000000, 32'hFF800000, 16'h0017, 1'b1, 6'd1,  32'h00000000, 32'hFF800000);
        idle(45);

        stall_arm = 1'b1;
        send(32'h00800000, 32'h00000000, 16'h0020, 1'b1, 6'd1,  32'h00800000, 32'h00000000);
        send(32'h00000000, 32'h00000000, 16'h0021, 1'b0, 6'd32, 32'h00000000, 32'h00000000);
        send(32'h00000000, 32'h00400000, 16'h0022, 1'b0, 6'd32, 32'hFFC00000, 32'h00400000);
        send(32'h00200000, 32'h00000000, 16'h0023, 1'b1, 6'd5,  32'h00C9D040, 32'h00000000);
        idle(50);
        chk("stall_seen", {63'd0, stall_done}, 64'd1);

        send(32'h00000000, 32'h00000000, 16'h0030, 1'b0, 6'd32, 32'h00000000, 32'h00000000);
        send(32'h00400000, 32'h00000000, 16'h0031, 1'b1, 6'd2,  32'h00800000, 32'h00000000);
        send(32'h00800000, 32'h00000000, 16'h0032, 1'b1, 6'd1,  32'h00800000, 32'h00000000);
        idle(20);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
        sb.delete();
        n_before = n_out;
        @(posedge clk); #2;
        reset = 1'b1;
        idle(40);
        chk("no_stale_output", 64'(n_out - n_before), 64'd0);

        send(32'h00400000, 32'h00000000, 16'h0077, 1'b1, 6'd2, 32'h00800000, 32'h00000000);
        idle(40);

`ifdef MANDELBROT_JULIA_EN
        send_julia(32'h00200000, 32'h0, 32'h0, 32'h0, 16'h0040, 1'b0, 6'd32, 32'h00000000, 32'h0);
        send_julia(32'h00800000, 32'h0, 32'h0, 32'h0, 16'h0041, 1'b1, 6'd0,  32'h00800000, 32'h0);
        send_julia(32'h00600000, 32'h0, 32'h7FE00000, 32'h0, 16'h0042, 1'b1, 6'd1, 32'h7FFFFFFF, 32'h0);
        send(32'h00400000, 32'h00000000, 16'h0043, 1'b1, 6'd2, 32'h00800000, 32'h00000000);
        idle(40);
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
